// File: rtl/ct_seq_controller_if.sv
// Result stream from the CT sequencer to its consumer.
// A beat transfers on a rising edge where res_valid && res_ready; the master holds
// res_data stable while res_valid=1 and res_ready=0, and never withdraws a valid beat
// except on abort or reset.
interface ct_seq_controller_if #(
  parameter int DW = 8
) ();
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;

  modport master (output res_valid, output res_data, input res_ready);
  modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/ct_seq_controller.sv
// Sequencer for the CT datapath: walks the kernel row-major, broadcasting one weight and
// the matching image window to the PE array per cycle, then streams the PE results out.
module ct_seq_controller #(
  parameter int DW       = 8,
  parameter int IMG      = 4,
  parameter int KER      = 3,
  parameter int PRE_DLY  = 5,
  parameter int PIPE_DLY = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [IMG*IMG*DW-1:0]                     image,
  input  logic [KER*KER*DW-1:0]                     kernel,
  input  logic [(IMG-KER+1)*(IMG-KER+1)*DW-1:0]     pe_result,
  output logic                                      clear,
  output logic [DW-1:0]                             weight_out,
  output logic [(IMG-KER+1)*(IMG-KER+1)*DW-1:0]     subject_in,
  output logic                                      busy,
  output logic                                      done,
  output logic [2:0]                                dbg_state,
  ct_seq_controller_if.master                       res
);

  localparam int OUT  = IMG - KER + 1;
  localparam int NRES = OUT * OUT;
  localparam int CMAX = (NRES > PRE_DLY) ? ((NRES > PIPE_DLY) ? NRES : PIPE_DLY)
                                         : ((PRE_DLY > PIPE_DLY) ? PRE_DLY : PIPE_DLY);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (KER > 1) ? $clog2(KER) : 1;

  localparam logic [CW-1:0] PRE_LAST   = CW'((PRE_DLY > 0) ? PRE_DLY - 1 : 0);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((PIPE_DLY > 0) ? PIPE_DLY - 1 : 0);
  localparam logic [CW-1:0] RES_LAST   = CW'(NRES - 1);
  localparam logic [RW-1:0] K_LAST     = RW'(KER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_PRE   = 3'd2,
    S_CALC  = 3'd3,
    S_DRAIN = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          r_q, r_d, c_q, c_d;

  logic                   clear_q, clear_d;
  logic [DW-1:0]          weight_q, weight_d;
  logic [NRES*DW-1:0]     subject_q, subject_d;
  logic                   busy_q, busy_d;
  logic                   res_valid_q, res_valid_d;
  logic [DW-1:0]          res_data_q, res_data_d;
  logic                   done_q, done_d;

  // State and all outputs share one register so outputs line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      clear_q     <= 1'b1;
      weight_q    <= '0;
      subject_q   <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      clear_q     <= clear_d;
      weight_q    <= weight_d;
      subject_q   <= subject_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      r_d     = '0;
      c_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_INIT;
        S_INIT: begin
          cnt_d   = '0;
          r_d     = '0;
          c_d     = '0;
          state_d = (PRE_DLY > 0) ? S_PRE : S_CALC;
        end
        S_PRE: begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CALC: begin
          if (c_q == K_LAST) begin
            c_d = '0;
            if (r_q == K_LAST) begin
              r_d     = '0;
              cnt_d   = '0;
              state_d = (PIPE_DLY > 0) ? S_DRAIN : S_OUT;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (res_valid_q && res.res_ready) begin
            if (cnt_q == RES_LAST) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state/counters so they register alongside the state.
  always_comb begin
    clear_d     = 1'b0;
    busy_d      = 1'b1;
    weight_d    = '0;
    subject_d   = '0;
    res_valid_d = 1'b0;
    res_data_d  = '0;
    done_d      = 1'b0;
    case (state_d)
      S_IDLE: begin
        clear_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_CALC: begin
        weight_d = kernel[(int'(r_d) * KER + int'(c_d)) * DW +: DW];
        for (int i = 0; i < OUT; i++) begin
          for (int j = 0; j < OUT; j++) begin
            subject_d[(i * OUT + j) * DW +: DW] =
              image[((i + int'(r_d)) * IMG + j + int'(c_d)) * DW +: DW];
          end
        end
      end
      S_OUT: begin
        res_valid_d = 1'b1;
        res_data_d  = pe_result[int'(cnt_d) * DW +: DW];
      end
      S_DONE: begin
        done_d  = 1'b1;
        clear_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign clear         = clear_q;
  assign weight_out    = weight_q;
  assign subject_in    = subject_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;
  assign res.res_valid = res_valid_q;
  assign res.res_data  = res_data_q;

endmodule

// File: tb/tb_ct_seq_controller.sv
// Directed bench for ct_seq_controller: default geometry plus a 5x5/2x2 zero-delay instance.
module tb_ct_seq_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  // Default instance
  logic         reset, start, abort;
  logic [127:0] image;
  logic [71:0]  kernel;
  logic [31:0]  pe_result;
  logic         clear, busy, done;
  logic [7:0]   weight_out;
  logic [31:0]  subject_in;
  logic [2:0]   dbg_state;
  ct_seq_controller_if #(.DW(8)) res_if ();

  ct_seq_controller u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .image(image), .kernel(kernel), .pe_result(pe_result),
    .clear(clear), .weight_out(weight_out), .subject_in(subject_in),
    .busy(busy), .done(done), .dbg_state(dbg_state), .res(res_if)
  );

  // IMG=5, KER=2, no pre/drain delay instance
  logic         start6, abort6;
  logic [199:0] image6;
  logic [31:0]  kernel6;
  logic [127:0] pe6;
  logic         clear6, busy6, done6;
  logic [7:0]   weight6;
  logic [127:0] subject6;
  logic [2:0]   state6;
  ct_seq_controller_if #(.DW(8)) res6_if ();

  ct_seq_controller #(.DW(8), .IMG(5), .KER(2), .PRE_DLY(0), .PIPE_DLY(0)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6), .abort(abort6),
    .image(image6), .kernel(kernel6), .pe_result(pe6),
    .clear(clear6), .weight_out(weight6), .subject_in(subject6),
    .busy(busy6), .done(done6), .dbg_state(state6), .res(res6_if)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"},   dbg_state, 0);
    chk({tag, "_clear"},   clear, 1);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_weight"},  weight_out, 0);
    chk({tag, "_subject"}, subject_in, 0);
    chk({tag, "_valid"},   res_if.res_valid, 0);
    chk({tag, "_done"},    done, 0);
  endtask

  // mode: 0 plain, 1 abort at stop_t, 2 abort+start at stop_t, 3 async reset at stop_t
  task automatic run(input int stall_len, input bit restart, input int mode, input int stop_t);
    int beat, stall_left, done_t;
    exp_q = {};
    exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    beat = 0; stall_left = stall_len; done_t = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("init_state", dbg_state, 1);
    chk("init_busy", busy, 1);
    chk("init_clear", clear, 0);
    for (int t = 1; t < 60; t++) begin
      @(negedge clk);
      start = 1'b0;
      case (t)
        1:  begin chk("pre_state", dbg_state, 2); chk("pre_weight", weight_out, 0); end
        6:  begin chk("step0_w", weight_out, 1); chk("step0_s", subject_in, 32'h06050201); end
        9:  begin chk("step3_w", weight_out, 4); chk("step3_s", subject_in, 32'h0a090605); end
        10: begin chk("step4_w", weight_out, 5); chk("step4_s", subject_in, 32'h0b0a0706); end
        14: begin chk("step8_w", weight_out, 9); chk("step8_s", subject_in, 32'h100f0c0b); end
        15: begin chk("drain_state", dbg_state, 4); chk("drain_w", weight_out, 0);
                  chk("drain_s", subject_in, 0); end
        default: ;
      endcase
      if (restart && (t == 8 || t == 17)) start = 1'b1;
      if (mode != 0 && t == stop_t) begin
        if (mode == 3) begin
          chk("pre_reset_state", dbg_state, 4);
          #3 reset = 1'b0;
          #1 chk_idle("async_reset");
          @(negedge clk);
          reset = 1'b1;
        end else begin
          if (mode == 2) chk("abort_out_valid", res_if.res_valid, 1);
          abort = 1'b1;
          if (mode == 2) start = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          start = 1'b0;
          chk_idle("abort");
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
          end
          chk("abort_stay_idle", dbg_state, 0);
        end
        return;
      end
      if (res_if.res_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
          res_if.res_ready = 1'b1;
        end else if (beat == 2 && stall_left > 0) begin
          res_if.res_ready = 1'b0;
          chk("stall_hold", res_if.res_data, exp_q[0]);
          stall_left--;
        end else begin
          res_if.res_ready = 1'b1;
          chk("beat", res_if.res_data, exp_q.pop_front());
          beat++;
        end
      end else begin
        res_if.res_ready = 1'b1;
      end
      if (done) begin
        done_t = t;
        break;
      end
    end
    res_if.res_ready = 1'b1;
    chk("done_cycle", done_t, 21 + stall_len);
    chk("beat_count", beat, 4);
    @(negedge clk);
    chk_idle("post_run");
  endtask

  task automatic run6();
    int beat, done_t;
    exp_q = {};
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h30 + k));
    beat = 0; done_t = -1;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    chk("r6_init", state6, 1);
    for (int t = 1; t < 60; t++) begin
      @(negedge clk);
      case (t)
        1: begin
          chk("r6_calc_state", state6, 3);
          chk("r6_step0_w", weight6, 1);
          chk("r6_step0_l0", subject6[7:0], 1);
          chk("r6_step0_l15", subject6[127:120], 19);
        end
        4: begin
          chk("r6_step3_w", weight6, 4);
          chk("r6_step3_l0", subject6[7:0], 7);
          chk("r6_step3_l15", subject6[127:120], 25);
        end
        5: chk("r6_out_state", state6, 5);
        default: ;
      endcase
      if (res6_if.res_valid) begin
        if (exp_q.size() == 0) chk("r6_extra_beat", 1, 0);
        else begin
          chk("r6_beat", res6_if.res_data, exp_q.pop_front());
          beat++;
        end
      end
      if (done6) begin
        done_t = t;
        break;
      end
    end
    chk("r6_done_cycle", done_t, 21);
    chk("r6_beat_count", beat, 16);
    @(negedge clk);
    chk("r6_idle", state6, 0);
    chk("r6_idle_busy", busy6, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    start6 = 1'b0; abort6 = 1'b0;
    res_if.res_ready = 1'b1;
    res6_if.res_ready = 1'b1;
    for (int i = 0; i < 16; i++) image[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < 9; i++)  kernel[i*8 +: 8] = 8'(i + 1);
    pe_result = {8'h22, 8'h21, 8'h12, 8'h11};
    for (int i = 0; i < 25; i++) image6[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < 4; i++)  kernel6[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < 16; i++) pe6[i*8 +: 8] = 8'(8'h30 + i);

    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_data", res_if.res_data, 0);
    reset = 1'b1;
    @(negedge clk);

    run(0, 1'b0, 0, 0);
    run(3, 1'b0, 0, 0);
    run(0, 1'b1, 0, 0);
    run(0, 1'b0, 1, 9);
    run(0, 1'b0, 0, 0);
    run(0, 1'b0, 2, 17);
    run(0, 1'b0, 0, 0);
    run(0, 1'b0, 3, 16);
    run(0, 1'b0, 0, 0);
    run6();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
